// File: rtl/tiled_matmul_sequencer_pkg.sv
// rtl/tiled_matmul_sequencer_pkg.sv - shared constants for the tiled matmul sequencer
//
// Purpose: FSM state encoding, memory-select codes and default parameter values
// shared by the sequencer top and its address generator.
// Ports: none (package).

package tiled_matmul_sequencer_pkg;

  localparam int DEF_BLOCK_SIZE   = 64;
  localparam int DEF_ADDR_WIDTH   = 12;
  localparam int DEF_CNT_WIDTH    = 4;
  localparam int DEF_A_BASE       = 0;
  localparam int DEF_B_BASE       = 1024;
  localparam int DEF_C_BASE       = 2048;
  localparam int DEF_EXEC_TIMEOUT = 1024;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_INIT_C   = 4'd1;
  localparam logic [3:0] ST_FETCH_A  = 4'd2;
  localparam logic [3:0] ST_FETCH_B  = 4'd3;
  localparam logic [3:0] ST_CORE_RST = 4'd4;
  localparam logic [3:0] ST_EXECUTE  = 4'd5;
  localparam logic [3:0] ST_READ_C   = 4'd6;
  localparam logic [3:0] ST_WRITE_C  = 4'd7;
  localparam logic [3:0] ST_NEXT     = 4'd8;
  localparam logic [3:0] ST_DONE     = 4'd9;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;

  // Busy means a job is in flight: everything except IDLE and DONE.
  function automatic logic state_is_busy(input logic [3:0] s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/tiled_matmul_sequencer_tile_addr_gen.sv
// rtl/tiled_matmul_sequencer_tile_addr_gen.sv - combinational tile base-address generator
//
// Purpose: maps tile indices (i, j, k) and the selected memory to a tile base address.
// Ports:
//   i_i, i_j, i_k      current tile indices
//   i_n_blocks         N (tiles in the N dimension)
//   i_k_blocks         K (tiles in the K dimension)
//   i_sel              memory select (SEL_A / SEL_B / SEL_C)
//   o_addr             tile base address, truncated to ADDR_WIDTH

module tile_addr_gen
  import tiled_matmul_sequencer_pkg::*;
#(
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int A_BASE     = DEF_A_BASE,
  parameter int B_BASE     = DEF_B_BASE,
  parameter int C_BASE     = DEF_C_BASE
) (
  input  logic [CNT_WIDTH-1:0]  i_i,
  input  logic [CNT_WIDTH-1:0]  i_j,
  input  logic [CNT_WIDTH-1:0]  i_k,
  input  logic [CNT_WIDTH-1:0]  i_n_blocks,
  input  logic [CNT_WIDTH-1:0]  i_k_blocks,
  input  logic [1:0]            i_sel,
  output logic [ADDR_WIDTH-1:0] o_addr
);

  localparam int LOG2_BS = $clog2(BLOCK_SIZE);
  // Product width wide enough that no tile offset can overflow before truncation.
  localparam int PW = 2 * CNT_WIDTH + LOG2_BS;
  localparam int SW = (PW > ADDR_WIDTH) ? PW : ADDR_WIDTH;

  logic [PW-1:0] w_i, w_j, w_k, w_nb, w_kb;
  logic [PW-1:0] w_a_off, w_b_off, w_c_off;
  logic [SW-1:0] w_a_sum, w_b_sum, w_c_sum;

  assign w_i  = PW'(i_i);
  assign w_j  = PW'(i_j);
  assign w_k  = PW'(i_k);
  assign w_nb = PW'(i_n_blocks);
  assign w_kb = PW'(i_k_blocks);

  // BLOCK_SIZE is a power of two, so scaling by it is a left shift.
  assign w_a_off = (w_i * w_kb + w_k) << LOG2_BS;
  assign w_b_off = (w_k * w_nb + w_j) << LOG2_BS;
  assign w_c_off = (w_i * w_nb + w_j) << LOG2_BS;

  assign w_a_sum = SW'(w_a_off) + SW'(A_BASE);
  assign w_b_sum = SW'(w_b_off) + SW'(B_BASE);
  assign w_c_sum = SW'(w_c_off) + SW'(C_BASE);

  always_comb begin
    o_addr = '0;
    case (i_sel)
      SEL_A:   o_addr = ADDR_WIDTH'(w_a_sum);
      SEL_B:   o_addr = ADDR_WIDTH'(w_b_sum);
      SEL_C:   o_addr = ADDR_WIDTH'(w_c_sum);
      default: o_addr = '0;
    endcase
  end

endmodule

// File: rtl/tiled_matmul_sequencer.sv
// rtl/tiled_matmul_sequencer.sv - tile-loop sequencer driving memory fetches and a systolic core
//
// Purpose: walks an M x N x K tile grid (k innermost), fetching A/B tiles, running the
// systolic core, and read-modify-writing the C tile, with optional C clear per output tile.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   start, abort                     job request (level), job termination
//   cfg_m/n/k_blocks, cfg_accumulate job configuration, latched on start
//   mem_req/ack/sel/we/init/addr     tile memory request handshake
//   systolic_rst/start/done          systolic core control
//   busy, done, err                  status

module tiled_matmul_sequencer
  import tiled_matmul_sequencer_pkg::*;
#(
  parameter int BLOCK_SIZE   = DEF_BLOCK_SIZE,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int A_BASE       = DEF_A_BASE,
  parameter int B_BASE       = DEF_B_BASE,
  parameter int C_BASE       = DEF_C_BASE,
  parameter int EXEC_TIMEOUT = DEF_EXEC_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  cfg_m_blocks,
  input  logic [CNT_WIDTH-1:0]  cfg_n_blocks,
  input  logic [CNT_WIDTH-1:0]  cfg_k_blocks,
  input  logic                  cfg_accumulate,
  output logic                  mem_req,
  input  logic                  mem_ack,
  output logic [1:0]            mem_sel,
  output logic                  mem_we,
  output logic                  mem_init,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  systolic_rst,
  output logic                  systolic_start,
  input  logic                  systolic_done,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int TW = $clog2(EXEC_TIMEOUT + 1);
  localparam logic [TW-1:0]        TMO_LAST = TW'(EXEC_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  logic [3:0]           r_state;
  logic [CNT_WIDTH-1:0] r_i, r_j, r_k;
  logic [CNT_WIDTH-1:0] r_m, r_n, r_kb;
  logic                 r_acc;
  logic                 r_err;
  logic [TW-1:0]        r_tmo;

  logic                  w_busy;
  logic                  w_cfg_zero;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_busy     = state_is_busy(r_state);
  assign w_cfg_zero = (cfg_m_blocks == '0) || (cfg_n_blocks == '0) || (cfg_k_blocks == '0);

  tile_addr_gen #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH),
    .A_BASE     (A_BASE),
    .B_BASE     (B_BASE),
    .C_BASE     (C_BASE)
  ) u_addr_gen (
    .i_i        (r_i),
    .i_j        (r_j),
    .i_k        (r_k),
    .i_n_blocks (r_n),
    .i_k_blocks (r_kb),
    .i_sel      (mem_sel),
    .o_addr     (w_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_m     <= '0;
      r_n     <= '0;
      r_kb    <= '0;
      r_acc   <= 1'b0;
      r_err   <= 1'b0;
      r_tmo   <= '0;
    end else if (abort && w_busy) begin
      // Abort outranks every other event in the cycle, including ack, done and timeout.
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_m   <= cfg_m_blocks;
            r_n   <= cfg_n_blocks;
            r_kb  <= cfg_k_blocks;
            r_acc <= cfg_accumulate;
            r_i   <= '0;
            r_j   <= '0;
            r_k   <= '0;
            if (w_cfg_zero) begin
              r_state <= ST_DONE;
              r_err   <= 1'b1;
            end else begin
              r_state <= cfg_accumulate ? ST_FETCH_A : ST_INIT_C;
              r_err   <= 1'b0;
            end
          end
        end
        ST_INIT_C:   if (mem_ack) r_state <= ST_FETCH_A;
        ST_FETCH_A:  if (mem_ack) r_state <= ST_FETCH_B;
        ST_FETCH_B:  if (mem_ack) r_state <= ST_CORE_RST;
        ST_CORE_RST: begin
          r_tmo   <= '0;
          r_state <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          if (systolic_done) begin
            r_state <= ST_READ_C;
          end else if (r_tmo == TMO_LAST) begin
            r_state <= ST_DONE;
            r_err   <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        ST_READ_C:   if (mem_ack) r_state <= ST_WRITE_C;
        ST_WRITE_C:  if (mem_ack) r_state <= ST_NEXT;
        ST_NEXT: begin
          if (r_k != r_kb - ONE) begin
            r_k     <= r_k + ONE;
            r_state <= ST_FETCH_A;
          end else if (r_j != r_n - ONE) begin
            r_k     <= '0;
            r_j     <= r_j + ONE;
            r_state <= r_acc ? ST_FETCH_A : ST_INIT_C;
          end else if (r_i != r_m - ONE) begin
            r_k     <= '0;
            r_j     <= '0;
            r_i     <= r_i + ONE;
            r_state <= r_acc ? ST_FETCH_A : ST_INIT_C;
          end else begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // err is held for the whole DONE window and dropped with the handshake.
          if (!start) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state register so reset clears them asynchronously.
  always_comb begin
    mem_req        = 1'b0;
    mem_sel        = SEL_A;
    mem_we         = 1'b0;
    mem_init       = 1'b0;
    systolic_rst   = 1'b0;
    systolic_start = 1'b0;
    case (r_state)
      ST_INIT_C: begin
        mem_req  = 1'b1;
        mem_sel  = SEL_C;
        mem_init = 1'b1;
      end
      ST_FETCH_A: begin
        mem_req = 1'b1;
        mem_sel = SEL_A;
      end
      ST_FETCH_B: begin
        mem_req = 1'b1;
        mem_sel = SEL_B;
      end
      ST_READ_C: begin
        mem_req = 1'b1;
        mem_sel = SEL_C;
      end
      ST_WRITE_C: begin
        mem_req = 1'b1;
        mem_sel = SEL_C;
        mem_we  = 1'b1;
      end
      ST_CORE_RST: systolic_rst   = 1'b1;
      ST_EXECUTE:  systolic_start = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr = mem_req ? w_addr : '0;
  assign busy     = w_busy;
  assign done     = (r_state == ST_DONE);
  assign err      = r_err;

endmodule

// File: tb/tb_tiled_matmul_sequencer.sv
// tb/tb_tiled_matmul_sequencer.sv - self-checking bench for tiled_matmul_sequencer

module tb_tiled_matmul_sequencer;

  localparam int CW  = 4;
  localparam int AW  = 12;
  localparam int BS  = 64;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, acc;
  logic [CW-1:0] cm, cn, ck;
  logic          mem_req, mem_ack, mem_we, mem_init;
  logic [1:0]    mem_sel;
  logic [AW-1:0] mem_addr;
  logic          sys_rst, sys_start, sys_done;
  logic          busy, done, err;

  always #5 clk = ~clk;

  tiled_matmul_sequencer #(
    .BLOCK_SIZE   (BS),
    .ADDR_WIDTH   (AW),
    .CNT_WIDTH    (CW),
    .A_BASE       (0),
    .B_BASE       (1024),
    .C_BASE       (2048),
    .EXEC_TIMEOUT (TMO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .cfg_m_blocks   (cm),
    .cfg_n_blocks   (cn),
    .cfg_k_blocks   (ck),
    .cfg_accumulate (acc),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .mem_sel        (mem_sel),
    .mem_we         (mem_we),
    .mem_init       (mem_init),
    .mem_addr       (mem_addr),
    .systolic_rst   (sys_rst),
    .systolic_start (sys_start),
    .systolic_done  (sys_done),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  typedef struct {
    int sel;
    int we;
    int init;
    int addr;
  } txn_t;

  txn_t exp_q[$];
  txn_t obs_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int ack_mode = 0;   // 0: ack tied high, 1: random 0-5 cycle delay
  int sys_mode = 0;   // 0: done 3 cycles after start, 1: never
  int exec_cnt = 0;
  int req_cycles = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  function automatic txn_t mk(input int s, input int w, input int n, input int a);
    txn_t t;
    t.sel = s; t.we = w; t.init = n; t.addr = a % 4096;
    return t;
  endfunction

  // Reference: the full ordered list of memory transactions a job must perform.
  task automatic build_model(input int m, input int n, input int k, input int a);
    exp_q.delete();
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++) begin
        if (a == 0) exp_q.push_back(mk(2, 0, 1, 2048 + (i * n + j) * BS));
        for (int kk = 0; kk < k; kk++) begin
          exp_q.push_back(mk(0, 0, 0, 0    + (i * k + kk) * BS));
          exp_q.push_back(mk(1, 0, 0, 1024 + (kk * n + j) * BS));
          exp_q.push_back(mk(2, 0, 0, 2048 + (i * n + j) * BS));
          exp_q.push_back(mk(2, 1, 0, 2048 + (i * n + j) * BS));
        end
      end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory and systolic-core responders.
  int  ack_cnt = 0;
  bit  ack_pend = 0;
  int  sys_cnt = 0;
  initial begin
    mem_ack  = 1'b0;
    sys_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ack_mode == 0) begin
        mem_ack = 1'b1;
      end else if (mem_req) begin
        if (!ack_pend) begin
          ack_pend = 1;
          ack_cnt  = $urandom_range(0, 5);
        end
        if (ack_cnt == 0) begin
          mem_ack  = 1'b1;
          ack_pend = 0;
        end else begin
          mem_ack = 1'b0;
          ack_cnt--;
        end
      end else begin
        mem_ack  = 1'b0;
        ack_pend = 0;
      end
      if (sys_start) begin
        sys_done = (sys_mode == 0) && (sys_cnt == 3);
        sys_cnt++;
      end else begin
        sys_done = 1'b0;
        sys_cnt  = 0;
      end
    end
  end

  // Compare process: every accepted transaction against the model, plus hold stability.
  bit prev_wait = 0;
  bit prev_rst = 0;
  int prev_bits = 0;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (mem_req) req_cycles++;
      if (mem_req && prev_wait)
        chk("req_hold_stable", int'({mem_sel, mem_we, mem_init, mem_addr}), prev_bits);
      if (mem_req && mem_ack && !abort) begin
        obs_q.push_back(mk(int'(mem_sel), int'(mem_we), int'(mem_init), int'(mem_addr)));
        if (exp_q.size() == 0) begin
          chk("txn_unexpected", 1, 0);
        end else begin
          txn_t t;
          t = exp_q.pop_front();
          chk("txn_sel",  int'(mem_sel),  t.sel);
          chk("txn_we",   int'(mem_we),   t.we);
          chk("txn_init", int'(mem_init), t.init);
          chk("txn_addr", int'(mem_addr), t.addr);
        end
      end
      if (sys_rst) begin
        exec_cnt++;
        chk("core_rst_one_cycle", int'(prev_rst), 0);
      end
      prev_wait = mem_req && !mem_ack;
      prev_bits = int'({mem_sel, mem_we, mem_init, mem_addr});
      prev_rst  = sys_rst;
    end else begin
      prev_wait = 0;
      prev_rst  = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_job(input int m, input int n, input int k, input int a);
    build_model(m, n, k, a);
    obs_q.delete();
    exec_cnt   = 0;
    req_cycles = 0;
    cm = CW'(m); cn = CW'(n); ck = CW'(k); acc = a[0];
    start = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
    chk("done_reached", int'(ok), 1);
  endtask

  task automatic release_job();
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("idle_after_done", int'({busy, done, err}), 0);
  endtask

  task automatic run_job(input int m, input int n, input int k, input int a, input bit scramble);
    start_job(m, n, k, a);
    if (scramble) begin
      tick();
      tick();
      cm = CW'($urandom_range(0, 15)); cn = CW'($urandom_range(0, 15));
      ck = CW'($urandom_range(0, 15)); acc = 1'($urandom_range(0, 1));
    end
    wait_done(5000);
    chk("job_err", int'(err), 0);
    chk("job_busy_at_done", int'(busy), 0);
    chk("model_remaining", exp_q.size(), 0);
    chk("exec_entries", exec_cnt, m * n * k);
    release_job();
  endtask

  function automatic int count_inits();
    int c;
    c = 0;
    foreach (obs_q[x]) if (obs_q[x].init != 0) c++;
    return c;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    bit seen;
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; acc = 1'b0;
    cm = '0; cn = '0; ck = '0;
    #3 rst_n = 1'b0;
    #1;
    chk("reset_outputs", int'({mem_req, mem_sel, mem_we, mem_init, sys_rst, sys_start, busy, done, err}), 0);
    chk("reset_addr", int'(mem_addr), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // 1x1x1 job, ack tied high, clear C first.
    ack_mode = 0; sys_mode = 0;
    run_job(1, 1, 1, 0, 0);
    chk("j1_txn_count", obs_q.size(), 5);
    if (obs_q.size() == 5) begin
      chk("j1_addr0", obs_q[0].addr, 2048);
      chk("j1_init0", obs_q[0].init, 1);
      chk("j1_addr1", obs_q[1].addr, 0);
      chk("j1_addr2", obs_q[2].addr, 1024);
      chk("j1_addr3", obs_q[3].addr, 2048);
      chk("j1_we3",   obs_q[3].we,   0);
      chk("j1_addr4", obs_q[4].addr, 2048);
      chk("j1_we4",   obs_q[4].we,   1);
    end

    // 2x3x2 job, zero-delay acks.
    run_job(2, 3, 2, 0, 0);
    chk("j2_exec_entries", exec_cnt, 12);
    chk("j2_init_count", count_inits(), 6);
    chk("j2_last_addr", obs_q[obs_q.size()-1].addr, 2368);
    chk("j2_last_we",   obs_q[obs_q.size()-1].we,   1);

    // Same job with random ack delays and cfg churn while busy.
    ack_mode = 1;
    run_job(2, 3, 2, 0, 1);
    chk("j3_exec_entries", exec_cnt, 12);
    chk("j3_last_addr", obs_q[obs_q.size()-1].addr, 2368);

    // Accumulate mode: no C clears.
    run_job(3, 2, 4, 1, 1);
    chk("j4_init_count", count_inits(), 0);

    // Zero tile count: immediate error, no memory traffic.
    ack_mode = 0;
    start_job(2, 2, 0, 0);
    wait_done(50);
    chk("zero_k_err", int'(err), 1);
    chk("zero_k_req_cycles", req_cycles, 0);
    release_job();
    start_job(0, 1, 1, 1);
    wait_done(50);
    chk("zero_m_err", int'(err), 1);
    chk("zero_m_req_cycles", req_cycles, 0);
    release_job();

    // Execute timeout.
    sys_mode = 1;
    start_job(1, 1, 1, 1);
    seen = 0;
    c0 = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (sys_start) begin
        seen = 1;
        c0 = cyc;
        break;
      end
    end
    chk("tmo_exec_seen", int'(seen), 1);
    wait_done(100);
    chk("tmo_cycles", cyc - c0, 16);
    chk("tmo_err", int'(err), 1);
    chk("tmo_txn_count", obs_q.size(), 2);
    release_job();
    sys_mode = 0;

    // Abort coinciding with mem_ack in FETCH_B.
    start_job(2, 2, 2, 0);
    seen = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (mem_req && mem_sel == 2'd1) begin
        seen = 1;
        abort = 1'b1;
        start = 1'b0;
        break;
      end
    end
    chk("abort_fetch_b_seen", int'(seen), 1);
    tick();
    abort = 1'b0;
    chk("abort_idle", int'({busy, done, err, mem_req, sys_start}), 0);
    // start together with abort in IDLE must be ignored.
    start = 1'b1;
    abort = 1'b1;
    tick();
    chk("start_with_abort_ignored", int'({busy, done}), 0);
    abort = 1'b0;
    run_job(1, 2, 1, 0, 0);
    chk("post_abort_first_addr", obs_q[0].addr, 2048);
    chk("post_abort_first_init", obs_q[0].init, 1);

    // Reset mid-job abandons it.
    ack_mode = 1;
    start_job(2, 2, 2, 0);
    repeat (15) tick();
    #1 rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("midreset_outputs", int'({mem_req, sys_start, sys_rst, busy, done, err}), 0);
    chk("midreset_addr", int'(mem_addr), 0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("after_reset_quiet", int'({busy, done, err, mem_req}), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tiled_matmul_sequencer.md
TILED_MATMUL_SEQUENCER -- requirements
Module: tiled_matmul_sequencer

Interface
REQ-001 Parameter BLOCK_SIZE, default 64, words per tile; power of two.
REQ-002 Parameter ADDR_WIDTH, default 12, memory address width.
REQ-003 Parameter CNT_WIDTH, default 4, width of each block-count field; up to 2^CNT_WIDTH-1 blocks per dimension.
REQ-004 Parameters A_BASE, B_BASE, C_BASE, default 0, 1024, 2048, tile-region base addresses.
REQ-005 Parameter EXEC_TIMEOUT, default 1024, maximum EXECUTE cycles before error.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  level request; sampled in IDLE.
REQ-009 abort  in  1  terminate the current job.
REQ-010 cfg_m_blocks, cfg_n_blocks, cfg_k_blocks  in  CNT_WIDTH each  tile counts for the M, N and K dimensions.
REQ-011 cfg_accumulate  in  1  1 = add to existing C (skip C init); 0 = clear C first.
REQ-012 mem_req  out  1  memory request; mem_ack  in  1  request accepted.
REQ-013 mem_sel  out  2  target memory: 0 = A, 1 = B, 2 = C; mem_we  out  1  write strobe (C only).
REQ-014 mem_init  out  1  C-tile clear request, qualifies mem_req; mem_addr  out  ADDR_WIDTH  tile base address.
REQ-015 systolic_rst, systolic_start  out  1 each; systolic_done  in  1.
REQ-016 busy, done, err  out  1 each  status.

Function
REQ-017 States: IDLE, INIT_C, FETCH_A, FETCH_B, CORE_RST, EXECUTE, READ_C, WRITE_C, NEXT, DONE.
REQ-018 In IDLE with start=1, the block latches all cfg_* inputs, clears i, j and k, and moves to DONE with err=1 if any count is 0; otherwise it moves to INIT_C (cfg_accumulate=0) or FETCH_A (cfg_accumulate=1).
REQ-019 Memory states (INIT_C, FETCH_A, FETCH_B, READ_C, WRITE_C) hold mem_req=1 with stable mem_sel, mem_we, mem_init and mem_addr until a cycle with mem_ack=1, and advance on the next edge.
REQ-020 mem_ack outside a memory state is ignored.
REQ-021 Addresses:
- A tile: A_BASE + (i*K + k)*BLOCK_SIZE.
- B tile: B_BASE + (k*N + j)*BLOCK_SIZE.
- C tile: C_BASE + (i*N + j)*BLOCK_SIZE.
- All products are computed at 2*CNT_WIDTH+log2(BLOCK_SIZE) bits, then truncated to ADDR_WIDTH.
REQ-022 Per-state outputs and transitions:
- INIT_C: mem_sel=2, mem_init=1.
- FETCH_A: mem_sel=0.
- FETCH_B: mem_sel=1.
- CORE_RST: systolic_rst=1 for exactly one cycle, then EXECUTE.
REQ-023 EXECUTE holds systolic_start=1 until systolic_done=1, then goes to READ_C; after EXEC_TIMEOUT cycles without systolic_done it goes to DONE with err=1.
REQ-024 READ_C uses mem_sel=2, mem_we=0; WRITE_C uses mem_sel=2, mem_we=1; WRITE_C then goes to NEXT.
REQ-025 Loop order is k innermost, then j, then i.
REQ-026 NEXT, depending on the indices:
- Last tile (i=M-1, j=N-1, k=K-1): go to DONE.
- k=K-1 otherwise: k wraps to 0, j advances (j wraps to 0 and i advances), then INIT_C if cfg_accumulate=0, else FETCH_A.
- Otherwise: k advances, then FETCH_A.
REQ-027 DONE asserts done=1 and holds err; it returns to IDLE when start=0.
REQ-028 busy=1 in every state except IDLE and DONE.
REQ-029 abort=1 in any busy state forces IDLE on the next edge: mem_req and systolic_start deassert that edge; no done pulse; err unchanged (0).
REQ-030 Simultaneous events: abort has priority over mem_ack, systolic_done and the timeout.
REQ-031 start=1 in IDLE with abort=1 is ignored.
REQ-032 cfg_* changes while busy have no effect on the current job.
REQ-033 Maximum job size M*N*K = (2^CNT_WIDTH-1)^3 tiles, with no counter overflow.

Reset
REQ-034 On rst_n=0, immediately and independent of clk:
- state = IDLE;
- i, j, k, timeout counter and latched configuration = 0;
- every output = 0 (mem_addr = 0).
REQ-035 Reset asserted mid-job abandons the job; no done or err follows rst_n deassertion.

Structure
REQ-036 A shared package holds the state encoding, the mem_sel codes (SEL_A, SEL_B, SEL_C) and the default parameter constants.
REQ-037 Address generation is one sub-module, tile_addr_gen: combinational, taking i, j, k, N, K and mem_sel, returning mem_addr.
REQ-038 The block contains no other sub-modules.

Verification
REQ-039 M=N=K=1, cfg_accumulate=0, mem_ack tied 1, systolic_done asserted 3 cycles after systolic_start: addresses observed are C 2048, A 0, B 1024, C 2048 read, C 2048 write; then done=1, err=0.
REQ-040 M=2, N=3, K=2, cfg_accumulate=0: exactly 12 EXECUTE entries, 6 INIT_C requests, and a last C write at address 2048+5*64=2368.
REQ-041 Random 0-5 cycle mem_ack delays: mem_addr, mem_sel and mem_we stay stable while mem_req=1 and not yet acked; the final result is identical to the zero-delay run.
REQ-042 cfg_k_blocks=0 with start=1: DONE, err=1, no mem_req ever asserted.
REQ-043 systolic_done never asserted, EXEC_TIMEOUT=16: DONE with err=1 exactly 16 cycles after EXECUTE entry.
REQ-044 abort in the same cycle as mem_ack during FETCH_B: IDLE next cycle, busy=0, done=0; a following start runs a clean job from i=j=k=0.
